sysace_stream_reader: RTL
=========================

Name: sysace_stream_reader

Overview:
Parametrised successor to the single-range SystemACE sector reader. Issues a sequence of multi-sector read commands to the SystemACE MPU controller over a run-time LBA window [lba_first, lba_last]. Packs incoming 16-bit words, with optional byte swap, into OUT_W-bit words for a downstream FIFO. Adds FIFO backpressure gating between commands, abort, command-acknowledge timeout, and sticky overflow/error status.

Parameters:
OUT_W, 128, output word width; multiple of 16; 16..512
SECT_CODE, 8'h00, nsectors code per command; 0 means 256 sectors
LBA_STEP, 28'd256, LBA increment per command; must equal sectors per command
SWAP_BYTES, 1, 1 = swap bytes within each 16-bit word before packing
ACK_TIMEOUT, 16, max cycles from sysace_start to sysace_busy high

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
start  in  1  single-cycle pulse; accepted only in IDLE
abort  in  1  pulse; stop after current command completes
lba_first  in  28  first LBA; sampled on accepted start
lba_last  in  28  LBA of last command; sampled on accepted start
mpulba  out  28  LBA of current command
nsectors  out  8  constant SECT_CODE
sysace_start  out  1  one-cycle command pulse
sysace_busy  in  1  controller busy
sysace_read_data  in  16  read word
sysace_read_avail  in  1  read word valid strobe (cannot be stalled)
wr_en  out  1  FIFO push
dout  out  OUT_W  packed word; first-received 16-bit word in MSBs
fifo_full  in  1  FIFO full
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse on return to IDLE
overflow  out  1  sticky; a packed word was dropped because fifo_full was high
ack_err  out  1  sticky; ACK_TIMEOUT expired
cmd_count  out  16  commands completed since last accepted start

Behaviour:
- Reset: state IDLE; mpulba=0; wr_en=0; dout=0; pack counter=0; done=0; overflow=0; ack_err=0; cmd_count=0; abort latch=0.
- States: IDLE, GATE, START, ACK, XFER, NEXT.
- IDLE: on start, latch lba_first into mpulba and lba_last into the end register; clear overflow, ack_err, cmd_count, abort latch and pack counter; go to GATE.
- GATE: wait while fifo_full=1; when fifo_full=0, go to START.
- START: sysace_start=1 for exactly this cycle; clear ack timer; go to ACK.
- ACK: sysace_busy=1 -> XFER. If the timer reaches ACK_TIMEOUT -> set ack_err, go to IDLE, pulse done.
- XFER: wait for sysace_busy=0; then increment cmd_count and go to NEXT.
- NEXT: if abort latch=1 or mpulba >= end register -> IDLE, pulse done; else mpulba += LBA_STEP (mod 2^28) and go to GATE.
- mpulba holds its value in IDLE after completion.
- abort: sampled in every non-IDLE state into the abort latch. It never truncates an in-flight command. abort in IDLE is ignored.
- start outside IDLE is ignored.
- Packer: runs in every state.
  - On sysace_read_avail, the (swapped if SWAP_BYTES) word shifts into dout from the LSB end, and the counter increments modulo OUT_W/16.
  - When the counter wraps, wr_en=1 on the following cycle, registered; dout is stable on that cycle.
  - If fifo_full=1 on that cycle, set overflow and force wr_en=0; the word is lost.
  - The counter does not reset between commands. Sector size times sector count is always a multiple of OUT_W/16 words, so no partial words arise.
- Simultaneous read_avail and RST: reset wins.
- Reset mid-command returns to IDLE immediately. The SystemACE controller is not notified.
- lba_last < lba_first: exactly one command, at lba_first.

Decomposition:
- Shared package sysace_pkg: state encoding constants, SECTOR_WORDS=256, LBA width 28, SECT_CODE to sector-count function.
- One natural sub-module: sysace_word_packer (byte swap, shift register, counter, wr_en/overflow generation), parametrised by OUT_W and SWAP_BYTES.

Test Plan:
- lba_first=0, lba_last=512, OUT_W=128; controller model returns 65536 words per command -> 3 sysace_start pulses at mpulba 0, 256, 512; 24576 wr_en pulses; cmd_count=3; done pulse; busy low.
- Data 16'h0102, 16'h0304, ... ×8 with SWAP_BYTES=1 -> first dout = 128'h0201_0403_0605_0807_0A09_0C0B_0E0D_100F.
- fifo_full held high in GATE for 50 cycles -> no sysace_start until fifo_full falls; start issued the cycle after it falls.
- fifo_full=1 on a packed-word cycle -> wr_en=0 that cycle, overflow=1 and held through the remainder of the run until the next start.
- abort pulsed mid-XFER of command 1 of 4 -> command completes, cmd_count=1, done pulses, no further sysace_start.
- sysace_busy never asserted -> ack_err=1 after 16 cycles in ACK; return to IDLE with done pulse; RST mid-XFER -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/sysace_pkg.sv
// Shared definitions for the SystemACE multi-sector stream reader:
// FSM encoding, LBA width and sector geometry.
package sysace_pkg;

    localparam int LBA_W        = 28;
    localparam int SECTOR_WORDS = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GATE,
        ST_START,
        ST_ACK,
        ST_XFER,
        ST_NEXT
    } state_t;

    // The controller encodes 256 sectors as a zero count.
    function automatic int sect_count(input logic [7:0] code);
        return (code == 8'h00) ? 256 : int'(code);
    endfunction

endpackage

// File: rtl/sysace_word_packer.sv
// Packs 16-bit SystemACE read words (optionally byte-swapped) into OUT_W-bit
// FIFO words; first-received word lands in the MSBs.
module sysace_word_packer #(
    parameter int OUT_W      = 128,
    parameter bit SWAP_BYTES = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_clr,
    input  logic [15:0]      i_data,
    input  logic             i_avail,
    input  logic             i_fifo_full,
    output logic             o_wr_en,
    output logic [OUT_W-1:0] o_dout,
    output logic             o_overflow
);

    localparam int NWORDS = OUT_W / 16;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    logic [OUT_W-1:0] r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pend;
    logic             r_overflow;

    logic [15:0]      w_word;
    logic             w_wrap;

    assign w_word = SWAP_BYTES ? {i_data[7:0], i_data[15:8]} : i_data;
    assign w_wrap = i_avail && (r_cnt == CNT_W'(NWORDS - 1));

    // NOTE: every register here is state, so all updates are non-blocking;
    // blocking assignments would let later statements see same-cycle values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_shift    <= '0;
            r_cnt      <= '0;
            r_pend     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (i_avail)
                r_shift <= (r_shift << 16) | OUT_W'(w_word);

            if (i_clr)
                r_cnt <= '0;
            else if (i_avail)
                r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;

            r_pend <= w_wrap;

            // A completed word meeting a full FIFO is dropped, not retried.
            if (i_clr)
                r_overflow <= 1'b0;
            else if (r_pend && i_fifo_full)
                r_overflow <= 1'b1;
        end
    end

    assign o_wr_en    = r_pend && !i_fifo_full;
    assign o_dout     = r_shift;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/sysace_stream_reader.sv
// Walks an LBA window issuing multi-sector SystemACE read commands, gating
// each command on FIFO space, and streams the packed data downstream.
module sysace_stream_reader
    import sysace_pkg::*;
#(
    parameter int               OUT_W       = 128,
    parameter logic [7:0]       SECT_CODE   = 8'h00,
    parameter logic [LBA_W-1:0] LBA_STEP    = 28'd256,
    parameter bit               SWAP_BYTES  = 1'b1,
    parameter int               ACK_TIMEOUT = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             abort,
    input  logic [LBA_W-1:0] lba_first,
    input  logic [LBA_W-1:0] lba_last,
    output logic [LBA_W-1:0] mpulba,
    output logic [7:0]       nsectors,
    output logic             sysace_start,
    input  logic             sysace_busy,
    input  logic [15:0]      sysace_read_data,
    input  logic             sysace_read_avail,
    output logic             wr_en,
    output logic [OUT_W-1:0] dout,
    input  logic             fifo_full,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             ack_err,
    output logic [15:0]      cmd_count
);

    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    state_t           r_state;
    logic [LBA_W-1:0] r_mpulba;
    logic [LBA_W-1:0] r_lba_end;
    logic             r_sysace_start;
    logic             r_done;
    logic             r_ack_err;
    logic [15:0]      r_cmd_count;
    logic             r_abort;
    logic [TMR_W-1:0] r_ack_tmr;

    logic             w_clr;

    assign w_clr = (r_state == ST_IDLE) && start;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state        <= ST_IDLE;
            r_mpulba       <= '0;
            r_lba_end      <= '0;
            r_sysace_start <= 1'b0;
            r_done         <= 1'b0;
            r_ack_err      <= 1'b0;
            r_cmd_count    <= '0;
            r_abort        <= 1'b0;
            r_ack_tmr      <= '0;
        end else begin
            r_sysace_start <= 1'b0;
            r_done         <= 1'b0;

            // Abort only takes effect at the next command boundary.
            if (r_state != ST_IDLE && abort)
                r_abort <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mpulba    <= lba_first;
                        r_lba_end   <= lba_last;
                        r_ack_err   <= 1'b0;
                        r_cmd_count <= '0;
                        r_abort     <= 1'b0;
                        r_state     <= ST_GATE;
                    end
                end
                ST_GATE: begin
                    if (!fifo_full) begin
                        r_sysace_start <= 1'b1;
                        r_state        <= ST_START;
                    end
                end
                ST_START: begin
                    r_ack_tmr <= '0;
                    r_state   <= ST_ACK;
                end
                ST_ACK: begin
                    if (sysace_busy) begin
                        r_state <= ST_XFER;
                    end else if (r_ack_tmr == TMR_W'(ACK_TIMEOUT - 1)) begin
                        r_ack_err <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_ack_tmr <= r_ack_tmr + 1'b1;
                    end
                end
                ST_XFER: begin
                    if (!sysace_busy) begin
                        r_cmd_count <= r_cmd_count + 1'b1;
                        r_state     <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (r_abort || r_mpulba >= r_lba_end) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_mpulba <= r_mpulba + LBA_STEP;
                        r_state  <= ST_GATE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    sysace_word_packer #(
        .OUT_W      (OUT_W),
        .SWAP_BYTES (SWAP_BYTES)
    ) u_packer (
        .CLK         (CLK),
        .RST         (RST),
        .i_clr       (w_clr),
        .i_data      (sysace_read_data),
        .i_avail     (sysace_read_avail),
        .i_fifo_full (fifo_full),
        .o_wr_en     (wr_en),
        .o_dout      (dout),
        .o_overflow  (overflow)
    );

    assign mpulba       = r_mpulba;
    assign nsectors     = SECT_CODE;
    assign sysace_start = r_sysace_start;
    assign busy         = (r_state != ST_IDLE);
    assign done         = r_done;
    assign ack_err      = r_ack_err;
    assign cmd_count    = r_cmd_count;

endmodule
